// File: rtl/multiword_negate.sv
// Streaming negator for wide sign-magnitude operands: one word per cycle, LSW first,
// passed through or two's-complement negated. Optional oZero output via MULTIWORD_NEGATE_ZERO_FLAG_EN.
module multiword_negate #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 64,
  parameter int CNT_W     = 7
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iSign,
  input  logic              iValid,
  input  logic [WORD_W-1:0] iData,
  output logic              oValid,
  output logic [WORD_W-1:0] oData,
  output logic              oLast,
  output logic              oFinish,
  output logic              oBusy
`ifdef MULTIWORD_NEGATE_ZERO_FLAG_EN
  ,
  output logic              oZero
`endif
);

  // Handshake: a word is taken in any cycle where iValid=1 in RUN, or iValid=1 together
  // with iStart in IDLE; there is no backpressure, the result appears one cycle later.
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              signQ;
  logic              seenQ;

  logic              accept;
  logic              curSign;
  logic              curSeen;
  logic [CNT_W-1:0]  curCnt;
  logic              isLast;
  logic              nextSeen;
  logic [WORD_W-1:0] outWord;

  // In the start cycle the operand context comes straight from the inputs.
  always_comb begin
    accept   = 1'b0;
    curSign  = signQ;
    curSeen  = seenQ;
    curCnt   = cnt;
    if (state == IDLE) begin
      accept  = iStart & iValid;
      curSign = iSign;
      curSeen = 1'b0;
      curCnt  = '0;
    end else begin
      accept  = iValid;
    end
    isLast   = (curCnt == CNT_W'(NUM_WORDS - 1));
    outWord  = iData;
    nextSeen = curSeen;
    if (curSign) begin
      if (curSeen) begin
        outWord = ~iData;
      end else if (iData != '0) begin
        outWord  = ~iData + WORD_W'(1);
        nextSeen = 1'b1;
      end else begin
        outWord = '0;
      end
    end
  end

`ifdef MULTIWORD_NEGATE_ZERO_FLAG_EN
  logic zeroAccQ;
  logic zeroPendQ;
  logic curZero;

  assign curZero = ((state == IDLE) ? 1'b1 : zeroAccQ) & (iData == '0);

  // The finished operand's flag waits in zeroPendQ so oZero changes together with oFinish.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      zeroAccQ  <= 1'b0;
      zeroPendQ <= 1'b0;
      oZero     <= 1'b0;
    end else begin
      if (state == IDLE && iStart) zeroAccQ <= accept ? curZero : 1'b1;
      else if (state == RUN && accept) zeroAccQ <= curZero;
      if (accept && isLast) zeroPendQ <= curZero;
      if (oLast) oZero <= zeroPendQ;
    end
  end
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      cnt     <= '0;
      signQ   <= 1'b0;
      seenQ   <= 1'b0;
      oValid  <= 1'b0;
      oData   <= '0;
      oLast   <= 1'b0;
      oFinish <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      oValid  <= accept;
      oLast   <= accept & isLast;
      oFinish <= oLast;
      if (accept) oData <= outWord;
      case (state)
        IDLE: begin
          if (iStart) begin
            signQ <= iSign;
            seenQ <= nextSeen;
            cnt   <= CNT_W'(accept);
            if (!(accept && isLast)) begin
              state <= RUN;
              oBusy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            seenQ <= nextSeen;
            if (isLast) begin
              state <= IDLE;
              oBusy <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
